// File: rtl/mul_arb_pkg.sv
// Shared types, default widths and popcount helper for the multiply/popcount arbiter.
package mul_arb_pkg;

  localparam int unsigned DEF_AW = 24;
  localparam int unsigned DEF_WW = 32;
  localparam int unsigned DEF_PW = 2 * DEF_AW;
  localparam int unsigned LW     = 6;

  typedef enum logic [1:0] {IDLE, MULT, COUNT, RESP} state_t;

  function automatic logic [LW-1:0] popcount(input logic [DEF_WW-1:0] v);
    logic [LW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DEF_WW; i++) c = c + LW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/mul_popcnt_core.sv
// Iterative shift-add multiplier, one multiplier bit per clock, with popcount/overflow taps.
// MUL_ARB_EARLY_TERM_EN: stop once the remaining multiplier bits are all zero.
module mul_popcnt_core
  import mul_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned WW = DEF_WW
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          start,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  output logic          done,
  output logic [WW-1:0] w,
  output logic [LW-1:0] l,
  output logic          ovf
);

  localparam int unsigned PW = 2 * AW;

  logic [PW-1:0] acc;
  logic [PW-1:0] a1_sh;
  logic [AW-1:0] a2_sh;
  logic          running;
  logic          last;

`ifdef MUL_ARB_EARLY_TERM_EN
  // Bit 0 is consumed this cycle; nothing left above it means this is the final step.
  assign last = (a2_sh[AW-1:1] == '0);
`else
  localparam int unsigned CW = $clog2(AW);
  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(AW - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)     cnt <= '0;
    else if (start)   cnt <= '0;
    else if (running) cnt <= cnt + CW'(1);
  end
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc     <= '0;
      a1_sh   <= '0;
      a2_sh   <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      a1_sh   <= PW'(a1);
      a2_sh   <= a2;
      running <= 1'b1;
    end else if (running) begin
      if (a2_sh[0]) acc <= acc + a1_sh;
      a1_sh <= a1_sh << 1;
      a2_sh <= a2_sh >> 1;
      if (last) running <= 1'b0;
    end
  end

  assign done = running & last;
  assign w    = acc[WW-1:0];
  assign ovf  = |acc[PW-1:WW];
  assign l    = popcount(DEF_WW'(w));

endmodule

// File: rtl/mul_popcnt_arbiter.sv
// Round-robin front end sharing one mul_popcnt_core among NREQ requesters.
// Optional MUL_ARB_EARLY_TERM_EN shortens MULT inside the core; results are unchanged.
module mul_popcnt_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned WW   = DEF_WW,
  parameter int unsigned IDW  = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*AW-1:0] req_a1,
  input  logic [NREQ*AW-1:0] req_a2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [WW-1:0]    rsp_w,
  output logic [LW-1:0]    rsp_l,
  output logic             rsp_ovf,
  output logic             busy,
  output logic [15:0]      op_count
);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, gnt_id, idx, id_q;
  logic           gnt_any, start, core_done, core_ovf;
  logic [WW-1:0]  core_w;
  logic [LW-1:0]  core_l;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NREQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && n_reset && gnt_any) req_ready[gnt_id] = 1'b1;
  end

  assign start = (state == IDLE) && gnt_any;
  assign busy  = (state != IDLE);

  mul_popcnt_core #(
    .AW (AW),
    .WW (WW)
  ) u_core (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start),
    .a1      (req_a1[gnt_id*AW +: AW]),
    .a2      (req_a2[gnt_id*AW +: AW]),
    .done    (core_done),
    .w       (core_w),
    .l       (core_l),
    .ovf     (core_ovf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MULT;
      MULT:    if (core_done) state_nxt = COUNT;
      COUNT:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_w     <= '0;
      rsp_l     <= '0;
      rsp_ovf   <= 1'b0;
      op_count  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        id_q <= gnt_id;
        ptr  <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
      if (state == COUNT) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_w     <= core_w;
        rsp_l     <= core_l;
        rsp_ovf   <= core_ovf;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mul_popcnt_arbiter.sv
// Scoreboard bench for mul_popcnt_arbiter: grants and results predicted from arithmetic rules.
module tb_mul_popcnt_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 24;
  localparam int unsigned WW   = 32;
  localparam int unsigned IDW  = 2;

  logic                 clk = 1'b0;
  logic                 n_reset = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_a1, req_a2;
  logic                 rsp_valid, rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [WW-1:0]        rsp_w;
  logic [5:0]           rsp_l;
  logic                 rsp_ovf, busy;
  logic [15:0]          op_count;

  always #5 clk = ~clk;

  mul_popcnt_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .WW   (WW),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a1    (req_a1),
    .req_a2    (req_a2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_w     (rsp_w),
    .rsp_l     (rsp_l),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy),
    .op_count  (op_count)
  );

  typedef struct {
    int unsigned id;
    logic [31:0] w;
    int unsigned l;
    bit          ovf;
    int unsigned k;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0, errors = 0, cyc = 0;
  int unsigned mptr = 0, mcount = 0, age = 0;
  bit          job_active = 0, rsp_seen = 0;
  int unsigned hs_count[NREQ] = '{default: 0};
  bit          timed_out = 0, timeout_seen = 0;

  function automatic exp_t model(input int unsigned id, input logic [AW-1:0] x,
                                 input logic [AW-1:0] y, input int unsigned k);
    exp_t e;
    longint unsigned px, py, p;
    int unsigned n;
    px = x;
    py = y;
    p  = px * py;
    e.id  = id;
    e.w   = p[31:0];
    e.l   = $countones(e.w);
    e.ovf = (p >> 32) != 0;
    e.k   = k;
    n = AW;
`ifdef MUL_ARB_EARLY_TERM_EN
    n = 1;
    for (int unsigned b = 0; b < AW; b++) if (y[b]) n = b + 1;
`endif
    e.lat = n + 2;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    int g;
    logic [NREQ-1:0] exp_rdy;
    if (!n_reset) begin
      checks++;
      if (req_ready != '0 || rsp_valid || rsp_id != '0 || rsp_w != '0 || rsp_l != '0 ||
          rsp_ovf || busy || op_count != '0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b valid=%b id=%0d w=%h l=%0d ovf=%b busy=%b count=%0d, expected all 0",
                 req_ready, rsp_valid, rsp_id, rsp_w, rsp_l, rsp_ovf, busy, op_count);
      end
      exp_q.delete();
      mptr = 0; mcount = 0; job_active = 0; rsp_seen = 0; age = 0;
    end else begin
      checks++;
      if (busy !== job_active) begin
        errors++;
        $display("FAIL busy: got %b expected %b (t=%0t)", busy, job_active, $time);
      end
      checks++;
      if (op_count !== 16'(mcount)) begin
        errors++;
        $display("FAIL op_count: got %0d expected %0d", op_count, 16'(mcount));
      end

      exp_rdy = '0;
      g = -1;
      if (!job_active)
        for (int i = 0; i < NREQ; i++) begin
          int j;
          j = (int'(mptr) + i) % NREQ;
          if (g < 0 && req_valid[j]) g = j;
        end
      if (g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL req_ready: got %b expected %b (t=%0t)", req_ready, exp_rdy, $time);
      end
      if (g >= 0) begin
        exp_q.push_back(model(g, req_a1[g*AW +: AW], req_a2[g*AW +: AW], cyc + 1));
        hs_count[g]++;
        mptr = (g + 1) % NREQ;
        job_active = 1;
        age = 0;
      end

      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: id=%0d w=%h with nothing outstanding", rsp_id, rsp_w);
        end else begin
          e = exp_q[0];
          if (rsp_id !== IDW'(e.id) || rsp_w !== e.w || rsp_l !== 6'(e.l) || rsp_ovf !== e.ovf) begin
            errors++;
            $display("FAIL rsp_fields: got id=%0d w=%h l=%0d ovf=%b expected id=%0d w=%h l=%0d ovf=%b",
                     rsp_id, rsp_w, rsp_l, rsp_ovf, e.id, e.w, e.l, e.ovf);
          end
          if (!rsp_seen) begin
            checks++;
            if (cyc + 1 - e.k != e.lat) begin
              errors++;
              $display("FAIL latency: got %0d cycles expected %0d", cyc + 1 - e.k, e.lat);
            end
            rsp_seen = 1;
          end
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            mcount++;
            job_active = 0;
            rsp_seen = 0;
          end
        end
      end else if (job_active) begin
        age++;
        if (age == 200) begin
          checks++;
          errors++;
          $display("FAIL watchdog: no response within %0d cycles", age);
        end
      end

      if (timed_out && !timeout_seen) begin
        timeout_seen = 1;
        checks++;
        errors++;
        $display("FAIL stimulus_timeout: wait bound expired, got busy=%b expected idle", busy);
      end
    end
  end

  logic [NREQ-1:0] pend;
  int unsigned     seen[NREQ];
  bit              rand_rdy;

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs_count[i] != seen[i]) begin
        seen[i] = hs_count[i];
        pend[i] = 1'b0;
        req_valid[i] = 1'b0;
      end
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input int i, input logic [AW-1:0] x, input logic [AW-1:0] y);
    pend[i] = 1'b1;
    req_a1[i*AW +: AW] = x;
    req_a2[i*AW +: AW] = y;
    req_valid[i] = 1'b1;
  endtask

  function automatic logic [AW-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return AW'(1) << $urandom_range(0, AW - 1);
      default: return AW'($urandom);
    endcase
  endfunction

  task automatic wait_idle(input int unsigned lim);
    int unsigned n = 0;
    while ((pend != '0 || job_active) && n < lim) begin
      tick();
      n++;
    end
    if (pend != '0 || job_active) timed_out = 1;
  endtask

  task automatic drop_all();
    req_valid = '0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) seen[i] = hs_count[i];
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    drop_all();
    tick();
    tick();
    n_reset = 1'b1;
  endtask

  initial begin
    bit reissued;
    int unsigned n;
    req_valid = '0; req_a1 = '0; req_a2 = '0; rsp_ready = 1'b1;
    pend = '0; rand_rdy = 0;
    for (int i = 0; i < NREQ; i++) seen[i] = 0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    tick();

    issue(0, 24'd3, 24'd5);
    wait_idle(200);
    issue(1, 24'hFFFFFF, 24'hFFFFFF);
    wait_idle(200);

    // Round robin from pointer 0 with all requesters valid; requester 0 comes back once.
    do_reset();
    for (int i = 0; i < NREQ; i++) issue(i, rnd_op(), rnd_op());
    reissued = 0;
    n = 0;
    while (!reissued && n < 100) begin
      tick();
      n++;
      if (!pend[0]) begin
        issue(0, rnd_op(), rnd_op());
        reissued = 1;
      end
    end
    wait_idle(400);

    // Backpressure with another requester waiting.
    rsp_ready = 1'b0;
    issue(2, AW'($urandom), AW'($urandom));
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    if (!rsp_valid) timed_out = 1;
    issue(3, AW'($urandom), AW'($urandom));
    repeat (10) tick();
    rsp_ready = 1'b1;
    wait_idle(200);

    // Reset ten cycles into MULT, then requesters 2 and 0 together.
    issue(3, AW'($urandom), AW'($urandom));
    n = 0;
    while (pend[3] && n < 20) begin tick(); n++; end
    repeat (10) tick();
    do_reset();
    issue(2, 24'd9, 24'd9);
    issue(0, 24'd11, 24'd13);
    wait_idle(200);

    // Zero operands and short multipliers.
    issue(1, 24'd0, 24'hABCDEF); wait_idle(200);
    issue(2, 24'h123456, 24'd0); wait_idle(200);
    issue(3, 24'd7, 24'd1);      wait_idle(200);
    issue(0, 24'd0, 24'd0);      wait_idle(200);
    issue(1, 24'hFFFFFF, 24'h800000); wait_idle(200);

    rand_rdy = 1;
    repeat (600) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 4) == 0) issue(i, rnd_op(), rnd_op());
    end
    rand_rdy = 0;
    rsp_ready = 1'b1;
    wait_idle(2000);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
